// File: rtl/layer1_pool_collector.sv
// Layer-1 output collector: 2x2 max-pools each conv tile into a 256-bit word.
// Words are queued in a first-word-fall-through FIFO with a frame-end tag.
module layer1_pool_collector #(
   parameter int unsigned BITS            = 16,
   parameter int unsigned BITS_SHIFT      = 4,
   parameter int unsigned CHANNEL_NUM     = 4,
   parameter int unsigned POOL_NUM        = 4,
   parameter int unsigned FIFO_DEPTH      = 4,
   parameter int unsigned FIFO_AW         = 2,
   parameter int unsigned TILES_PER_FRAME = 49,
   parameter int unsigned CNT_W           = 6
) (
   input  logic                                  clk_in,
   input  logic                                  rst_n,
   input  logic                                  clear,
   input  logic                                  in_valid,
   input  logic [POOL_NUM*CHANNEL_NUM*4*BITS-1:0] data_in,
   input  logic                                  out_ready,
   output logic                                  out_valid,
   output logic [CHANNEL_NUM*POOL_NUM*BITS-1:0]  data_out,
   output logic                                  out_last,
   output logic                                  overflow,
   output logic [FIFO_AW:0]                      fifo_level
);

   localparam int unsigned WordW = CHANNEL_NUM * POOL_NUM * BITS;
   localparam logic [CNT_W-1:0]   LastTile = CNT_W'(TILES_PER_FRAME - 1);
   localparam logic [CNT_W-1:0]   CntOne   = CNT_W'(1);
   localparam logic [FIFO_AW-1:0] PtrOne   = FIFO_AW'(1);
   localparam logic [FIFO_AW:0]   LvlOne   = (FIFO_AW + 1)'(1);
   localparam logic [FIFO_AW:0]   LvlFull  = (FIFO_AW + 1)'(FIFO_DEPTH);

   logic [WordW-1:0]   w_pool;
   logic               r_s1_vld;
   logic [WordW-1:0]   r_s1_word;
   logic [WordW-1:0]   r_mem_data [FIFO_DEPTH];
   logic               r_mem_last [FIFO_DEPTH];
   logic [FIFO_AW-1:0] r_wr_ptr;
   logic [FIFO_AW-1:0] r_rd_ptr;
   logic [FIFO_AW:0]   r_level;
   logic [CNT_W-1:0]   r_tile_cnt;
   logic               r_overflow;
   logic               w_empty;
   logic               w_full;
   logic               w_pop;
   logic               w_push;
   logic               w_drop;
   logic               w_last_tag;

   // Input element (l,v,t,u) is pool-major; output element (v,l) is channel-major.
   for (genvar gl = 0; gl < POOL_NUM; gl++) begin : g_pool
      for (genvar gv = 0; gv < CHANNEL_NUM; gv++) begin : g_chan
         localparam int unsigned InBase  = ((gl * CHANNEL_NUM + gv) * 4) << BITS_SHIFT;
         localparam int unsigned OutBase = (gv * POOL_NUM + gl) << BITS_SHIFT;
         logic [BITS-1:0] w_e0, w_e1, w_e2, w_e3, w_m01, w_m23;
         assign w_e0  = data_in[InBase +: BITS];
         assign w_e1  = data_in[InBase + BITS +: BITS];
         assign w_e2  = data_in[InBase + 2 * BITS +: BITS];
         assign w_e3  = data_in[InBase + 3 * BITS +: BITS];
         assign w_m01 = (w_e0 > w_e1) ? w_e0 : w_e1;
         assign w_m23 = (w_e2 > w_e3) ? w_e2 : w_e3;
         assign w_pool[OutBase +: BITS] = (w_m01 > w_m23) ? w_m01 : w_m23;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_vld  <= 1'b0;
         r_s1_word <= '0;
      end else begin
         r_s1_vld <= in_valid & ~clear;
         if (in_valid && !clear) r_s1_word <= w_pool;
      end
   end

   assign w_empty    = (r_level == '0);
   assign w_full     = (r_level == LvlFull);
   assign w_pop      = ~w_empty & out_ready;
   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign w_push     = r_s1_vld & (~w_full | w_pop);
   assign w_drop     = r_s1_vld & w_full & ~w_pop;
   assign w_last_tag = (r_tile_cnt == LastTile);

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_tile_cnt <= '0;
         r_overflow <= 1'b0;
      end else if (clear) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_tile_cnt <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr   <= r_wr_ptr + PtrOne;
            r_tile_cnt <= w_last_tag ? '0 : r_tile_cnt + CntOne;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + PtrOne;
         if (w_push && !w_pop) begin
            r_level <= r_level + LvlOne;
         end else if (!w_push && w_pop) begin
            r_level <= r_level - LvlOne;
         end
         if (w_drop) r_overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (w_push && !clear) begin
         r_mem_data[r_wr_ptr] <= r_s1_word;
         r_mem_last[r_wr_ptr] <= w_last_tag;
      end
   end

   // Masking keeps the outputs at zero while the (unreset) memory holds stale data.
   assign out_valid  = ~w_empty;
   assign data_out   = w_empty ? '0 : r_mem_data[r_rd_ptr];
   assign out_last   = ~w_empty & r_mem_last[r_rd_ptr];
   assign overflow   = r_overflow;
   assign fifo_level = r_level;

endmodule

// File: doc/layer1_pool_collector.md
Name: layer1_pool_collector

Overview:
- Consumer at the output end of the layer-1 convolution top.
- Accepts each registered 1024-bit conv result (4 pools × 4 channels × 2×2 × 16-bit ReLU'd values), performs 2×2 unsigned max-pooling and packs the 16 pooled values into one 256-bit word.
- Buffers words in a small first-word-fall-through FIFO and streams them to layer 2 over a valid/ready handshake.
- Tags the last word of each frame.

Parameters:
- BITS, 16, element width.
- BITS_SHIFT, 4, log2(BITS).
- CHANNEL_NUM, 4, conv output channels.
- POOL_NUM, 4, 2×2 pool windows per input tile.
- FIFO_DEPTH, 4, output FIFO entries (power of 2).
- FIFO_AW, 2, log2(FIFO_DEPTH).
- TILES_PER_FRAME, 49, input tiles per image (28×28 image in 4×4 tiles, 7×7).
- CNT_W, 6, tile counter width (must satisfy 2^CNT_W ≥ TILES_PER_FRAME).

Ports:
- clk_in  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- clear  input  1  synchronous flush of pipeline, FIFO, counter and overflow flag.
- in_valid  input  1  data_in holds one tile this cycle; one tile per high cycle.
- data_in  input  1024  element (l,v,t,u) at bit offset ((l*256)+((v*4+t*2+u)*16)), 16 bits, unsigned. l = pool index, v = channel, t/u = row/col inside the window.
- out_ready  input  1  downstream accepts a word.
- out_valid  output  1  FIFO head valid.
- data_out  output  256  pooled word; element (v,l) at bits ((v*4+l)*16)+15 : (v*4+l)*16 (channel-major).
- out_last  output  1  head word is the final word of the frame.
- overflow  output  1  sticky; set when a tile was dropped.
- fifo_level  output  FIFO_AW+1  current FIFO occupancy, 0..FIFO_DEPTH.

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, data_out=0, out_last=0, overflow=0, fifo_level=0, pipeline valid=0, tile counter=0. Memory contents don't care.
- Stage 1 (capture):
  - When in_valid=1, register pool_word and stage1_vld=1; otherwise stage1_vld=0.
  - For each (l,v): pool_word element (v,l) = unsigned max of the 4 elements (l,v,0..1,0..1). Ties need no special handling.
- Stage 2 (FIFO write): when stage1_vld=1, write pool_word plus a last tag.
  - last tag = 1 when the tile counter equals TILES_PER_FRAME-1.
  - The tile counter increments per accepted write and wraps to 0 after TILES_PER_FRAME-1.
- Latency: in_valid at cycle N → stage1 at edge N+1 → FIFO entry written at edge N+2. With an empty FIFO, out_valid=1 during cycle N+2.
- FIFO read:
  - First-word-fall-through: data_out/out_last show the head whenever out_valid=1.
  - Pop occurs on a rising edge where out_valid & out_ready.
  - data_out holds stable while out_valid=1 and out_ready=0.
- Full FIFO:
  - Full with stage1_vld=1 and no pop that edge: the word is dropped, overflow←1, tile counter not advanced.
  - Full with a simultaneous pop: both the push and the pop occur, level unchanged, no overflow.
- Empty FIFO: out_valid=0. out_ready ignored; level never underflows.
- Pointers wrap modulo FIFO_DEPTH. fifo_level = writes minus reads.
- clear=1:
  - At the next edge, stage1_vld←0, FIFO emptied, counter←0, overflow←0.
  - Any in_valid in the same cycle is discarded (clear wins).
  - data_out value is don't-care while out_valid=0.
- Reset asserted mid-stream: asynchronous return to the reset values regardless of handshake state. A partially consumed frame is lost.
- overflow: cleared only by clear or rst_n.
- No combinational path from in_valid/data_in to any output. out_valid, data_out and out_last derive from registers only.

Test Plan:
- Single tile, all 4 elements of pool l=2, channel v=1 = {0x0003,0x7FFF,0x0010,0x8000}, others 0, out_ready=1:
  - required: out_valid at N+2.
  - required: data_out bits[(1*4+2)*16+15:(1*4+2)*16]=0x8000, all other fields 0.
  - required: fifo_level returns to 0 after the pop.
- Backpressure: out_ready=0, 4 consecutive tiles with max values 1,2,3,4 in element (0,0):
  - required: fifo_level=4.
  - required: a 5th tile is dropped and overflow=1.
  - required: after out_ready=1, words pop in order 1,2,3,4, then out_valid=0.
- Full-plus-pop: fill to 4, then present tile 5 so its FIFO write coincides with a pop (out_ready=1):
  - required: no overflow, level stays 4.
  - required: output order 1,2,3,4,5.
- Frame tagging: 98 tiles streamed with out_ready=1:
  - required: out_last=1 exactly on words 49 and 98, 0 elsewhere.
  - required: the counter wraps to 0 after each frame.
- clear in the same cycle as in_valid with 2 words buffered:
  - required: next cycle fifo_level=0, out_valid=0, overflow=0.
  - required: the next frame's 49th word has out_last=1.
- Async reset: assert rst_n=0 between clock edges while out_valid=1 and out_ready=0:
  - required: out_valid, data_out, fifo_level, overflow go to 0 immediately, without waiting for a clock edge.
